// File: rtl/saisie_operande_pkg.sv
// Shared definitions for the keypad operand-entry controller.
// Contents: key-code constants, FSM state encoding and the largest
// operand value an 8-bit selector input can take.
package saisie_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_BKSP  = 4'hC;
    localparam logic [3:0] KEY_DMAX  = 4'h9;

    localparam logic [9:0] MAX_VAL   = 10'd255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/saisie_operande_if.sv
// Key-event / operand bus between the keypad source and the operand-entry
// controller.
//   key_valid, key_code : key events from the keypad (master -> slave)
//   num, okA            : committed operand and its one-cycle load strobe
//   preview, ndig       : display value and digit count of the entry so far
//   err                 : one-cycle pulse for a rejected key
interface saisie_operande_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] num;
    logic       okA;
    logic [7:0] preview;
    logic [1:0] ndig;
    logic       err;

    modport master (
        output key_valid, key_code,
        input  num, okA, preview, ndig, err
    );

    modport slave (
        input  key_valid, key_code,
        output num, okA, preview, ndig, err
    );
endinterface

// File: rtl/saisie_operande_bcd3_to_bin.sv
// Combinational conversion of a three-digit BCD stack into binary.
//   d2, d1, d0 : BCD digits, d0 least significant (most recently entered)
//   count      : number of digits held; digits above the count read as 0
//   value      : 10-bit binary value (0..999)
module bcd3_to_bin (
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [1:0] count,
    output logic [9:0] value
);
    logic [9:0] w2_s;
    logic [9:0] w1_s;
    logic [9:0] w0_s;

    // Mask unheld digits, then weight by 100 and 10 using shift-adds.
    always_comb begin
        w2_s = (count >= 2'd3) ? {6'd0, d2} : 10'd0;
        w1_s = (count >= 2'd2) ? {6'd0, d1} : 10'd0;
        w0_s = (count >= 2'd1) ? {6'd0, d0} : 10'd0;
        value = (w2_s << 6) + (w2_s << 5) + (w2_s << 2)
              + (w1_s << 3) + (w1_s << 1)
              + w0_s;
    end
endmodule

// File: rtl/saisie_operande.sv
// Keypad operand-entry controller for operand selector A.
// Assembles up to MAX_DIGITS decimal digits into an 8-bit operand and, on
// Enter, presents it on num with a one-cycle okA strobe.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : key events in; num/okA/preview/ndig/err out (all registered
//           or derived from registered state only)
module saisie_operande
    import saisie_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    saisie_operande_if.slave  bus
);
    localparam logic [1:0] MAX_NDIG = 2'(MAX_DIGITS);

    state_e     state_q, state_d;
    logic [3:0] d2_q, d2_d;
    logic [3:0] d1_q, d1_d;
    logic [3:0] d0_q, d0_d;
    logic [1:0] ndig_q, ndig_d;
    logic [7:0] num_q, num_d;
    logic       oka_q, oka_d;
    logic       err_q, err_d;

    logic [9:0] preview_s;
    logic [9:0] cand_s;
    logic       is_digit_s;

    bcd3_to_bin u_preview (
        .d2    (d2_q),
        .d1    (d1_q),
        .d0    (d0_q),
        .count (ndig_q),
        .value (preview_s)
    );

    // Candidate value if the current key were appended: preview*10 + k.
    always_comb begin
        cand_s     = (preview_s << 3) + (preview_s << 1) + {6'd0, bus.key_code};
        is_digit_s = (bus.key_code <= KEY_DMAX);
    end

    // Next-state logic for the FSM, digit stack and output strobes.
    always_comb begin
        state_d = state_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        ndig_d  = ndig_q;
        num_d   = num_q;
        oka_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            // Keys arriving while the strobe is out are dropped.
            COMMIT: begin
                state_d = IDLE;
            end
            IDLE, ENTRY: begin
                if (bus.key_valid) begin
                    if (is_digit_s) begin
                        // ndig check first: with a full stack cand_s can wrap.
                        if ((ndig_q == MAX_NDIG) || (cand_s > MAX_VAL)) begin
                            err_d = 1'b1;
                        end else begin
                            d2_d    = d1_q;
                            d1_d    = d0_q;
                            d0_d    = bus.key_code;
                            ndig_d  = ndig_q + 2'd1;
                            state_d = ENTRY;
                        end
                    end else if (bus.key_code == KEY_ENTER) begin
                        if (state_q == ENTRY) begin
                            num_d   = preview_s[7:0];
                            oka_d   = 1'b1;
                            d2_d    = 4'd0;
                            d1_d    = 4'd0;
                            d0_d    = 4'd0;
                            ndig_d  = 2'd0;
                            state_d = COMMIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        d2_d    = 4'd0;
                        d1_d    = 4'd0;
                        d0_d    = 4'd0;
                        ndig_d  = 2'd0;
                        state_d = IDLE;
                    end else if (bus.key_code == KEY_BKSP) begin
                        if (state_q == ENTRY) begin
                            d0_d   = d1_q;
                            d1_d   = d2_q;
                            d2_d   = 4'd0;
                            ndig_d = ndig_q - 2'd1;
                            if (ndig_q == 2'd1) begin
                                state_d = IDLE;
                            end else begin
                                state_d = ENTRY;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                d2_d    = 4'd0;
                d1_d    = 4'd0;
                d0_d    = 4'd0;
                ndig_d  = 2'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
            ndig_q  <= 2'd0;
            num_q   <= 8'd0;
            oka_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            ndig_q  <= ndig_d;
            num_q   <= num_d;
            oka_q   <= oka_d;
            err_q   <= err_d;
        end
    end

    assign bus.num     = num_q;
    assign bus.okA     = oka_q;
    assign bus.preview = preview_s[7:0];
    assign bus.ndig    = ndig_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_saisie_operande.sv
// Directed bench for saisie_operande: key sequences driven on the falling
// edge, outputs sampled on the following falling edge, committed operands
// checked against a queue of expected values as okA pulses appear.
module tb_saisie_operande;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   commits;
    logic [7:0] exp_q[$];

    saisie_operande_if bus_if ();

    saisie_operande #(.MAX_DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every okA cycle must match the next expected operand.
    always @(negedge clk) begin
        if (bus_if.okA === 1'b1) begin
            commits++;
            if (exp_q.size() == 0) begin
                chk("unexpected_okA", 10'd1, 10'd0);
            end else begin
                chk("commit_num", {2'b00, bus_if.num}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus_if.key_valid = 1'b1;
        bus_if.key_code  = k;
        @(negedge clk);
        bus_if.key_valid = 1'b0;
    endtask

    task automatic look(input string tag, input int pv, input int nd, input logic e);
        chk({tag, "_preview"}, {2'b00, bus_if.preview}, 10'(pv));
        chk({tag, "_ndig"}, {8'd0, bus_if.ndig}, 10'(nd));
        chk({tag, "_err"}, {9'd0, bus_if.err}, {9'd0, e});
    endtask

    initial begin
        checks = 0; failures = 0; commits = 0;
        bus_if.key_valid = 1'b0;
        bus_if.key_code  = 4'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        look("reset", 0, 0, 1'b0);
        chk("reset_num", {2'b00, bus_if.num}, 10'd0);
        chk("reset_okA", {9'd0, bus_if.okA}, 10'd0);
        rst_n = 1'b1;

        // 1,2,8, Enter -> 128
        press(4'd1); look("k1", 1, 1, 1'b0);
        press(4'd2); look("k12", 12, 2, 1'b0);
        press(4'd8); look("k128", 128, 3, 1'b0);
        exp_q.push_back(8'd128);
        press(4'hA);
        chk("ent128_okA", {9'd0, bus_if.okA}, 10'd1);
        look("ent128", 0, 0, 1'b0);
        @(negedge clk);
        chk("ent128_okA_low", {9'd0, bus_if.okA}, 10'd0);
        chk("ent128_num_hold", {2'b00, bus_if.num}, 10'd128);

        // 2,5,6 rejected at 6, then 5 -> 255
        press(4'd2); press(4'd5);
        press(4'd6); look("k256", 25, 2, 1'b1);
        @(negedge clk); chk("err_one_cycle", {9'd0, bus_if.err}, 10'd0);
        press(4'd5); look("k255", 255, 3, 1'b0);
        exp_q.push_back(8'd255);
        press(4'hA);
        chk("ent255_okA", {9'd0, bus_if.okA}, 10'd1);

        // 1,2,3,4 full stack, backspace twice, clear
        press(4'd1); press(4'd2); press(4'd3);
        press(4'd4); look("k1234", 123, 3, 1'b1);
        press(4'hC); look("bk1", 12, 2, 1'b0);
        press(4'hC); look("bk2", 1, 1, 1'b0);
        press(4'hB); look("clr", 0, 0, 1'b0);
        press(4'hC); look("bk_idle", 0, 0, 1'b0);

        // Enter in IDLE rejected, num held; unknown code ignored
        press(4'hA); look("ent_idle", 0, 0, 1'b1);
        chk("ent_idle_okA", {9'd0, bus_if.okA}, 10'd0);
        chk("ent_idle_num", {2'b00, bus_if.num}, 10'd255);
        press(4'd6); press(4'hE); look("unk", 6, 1, 1'b0);

        // Back-to-back digits, then leading zeros
        press(4'hB);
        @(negedge clk); bus_if.key_valid = 1'b1; bus_if.key_code = 4'd3;
        @(negedge clk); bus_if.key_code = 4'd4;
        @(negedge clk); bus_if.key_valid = 1'b0;
        look("b2b", 34, 2, 1'b0);
        press(4'hB);
        press(4'd0); press(4'd0); press(4'd7); look("lead0", 7, 3, 1'b0);
        press(4'd1); look("lead0_full", 7, 3, 1'b1);
        press(4'hB);

        // 7, Enter, then 9 during COMMIT (dropped)
        press(4'd7);
        exp_q.push_back(8'd7);
        @(negedge clk); bus_if.key_valid = 1'b1; bus_if.key_code = 4'hA;
        @(negedge clk); bus_if.key_code = 4'd9;
        chk("ent7_num", {2'b00, bus_if.num}, 10'd7);
        @(negedge clk); bus_if.key_valid = 1'b0;
        chk("drop9_okA", {9'd0, bus_if.okA}, 10'd0);
        look("drop9", 0, 0, 1'b0);

        // 4,2, Enter, reset sampled on the COMMIT cycle
        press(4'd4); press(4'd2);
        exp_q.push_back(8'd42);
        press(4'hA);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstc_okA", {9'd0, bus_if.okA}, 10'd0);
        chk("rstc_num", {2'b00, bus_if.num}, 10'd0);
        look("rstc", 0, 0, 1'b0);
        rst_n = 1'b1;
        press(4'd5); look("after_rst", 5, 1, 1'b0);

        @(negedge clk);
        chk("queue_empty", 10'(exp_q.size()), 10'd0);
        chk("commit_count", 10'(commits), 10'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
